// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the multi-channel LFSR coordinate generator.
//   - state_t: controller FSM states (IDLE, READY, STEP)
//   - TAPS_Wn: maximal-length Fibonacci feedback masks for widths 8..16.
//     Bit i set means state[i] feeds the XOR; the shift is towards the MSB.
//   - SEED_DEFAULT_W12 / CH_SALT_W12: default zero-seed substitute and
//     per-channel salt for the 12-bit configuration.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    STEP  = 2'd2
  } state_t;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [8:0]  TAPS_W9  = 9'h110;
  localparam logic [9:0]  TAPS_W10 = 10'h240;
  localparam logic [10:0] TAPS_W11 = 11'h500;
  localparam logic [11:0] TAPS_W12 = 12'hE08;
  localparam logic [12:0] TAPS_W13 = 13'h100D;
  localparam logic [13:0] TAPS_W14 = 14'h2015;
  localparam logic [14:0] TAPS_W15 = 15'h6000;
  localparam logic [15:0] TAPS_W16 = 16'hD008;

  localparam logic [11:0] SEED_DEFAULT_W12 = 12'hACE;
  localparam logic [11:0] CH_SALT_W12      = 12'h5A5;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: one WIDTH-bit Fibonacci LFSR register.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (state -> 0)
//   load            - load load_val this edge (has priority over step)
//   step            - shift one position this edge
//   seed            - already-salted seed for this channel
//   load_val        - value a load would store (seed, or SEED_DEFAULT if zero)
//   next_val        - value a step would store, from the current state
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 12,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W12,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_W12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_val
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    // A zero seed would lock the register at zero forever.
    load_val = (seed == '0) ? SEED_DEFAULT : seed;
    // Feedback is taken from the pre-shift state.
    next_val = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    state_d  = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = next_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/lfsr_multi.sv
// lfsr_multi: NUM_CH independent LFSR channels producing coordinate sets.
// Optional macro LFSR_MULTI_RANGE_EN enables rejection of values >= LIMIT.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - level; while high every channel reloads from seed_in
//   seed_in     - channel c at [c*WIDTH +: WIDTH]
//   fetch       - request for a new coordinate set
//   coord       - registered coordinates, same packing as seed_in
//   ack         - one-cycle pulse, coord is new this cycle
//   busy        - high while stepping
//   seeded      - high once any load has happened since reset
//   dbg_state   - current FSM state (lfsr_pkg::state_t encoding)
// Handshake: fetch is sampled only in READY with start low; each accepted
// fetch produces exactly one ack pulse unless aborted by start or reset.
// fetch while busy or in IDLE is dropped, never queued.
module lfsr_multi
  import lfsr_pkg::*;
#(
  parameter int               WIDTH           = 12,
  parameter int               NUM_CH          = 2,
  parameter logic [WIDTH-1:0] TAPS            = TAPS_W12,
  parameter int               STEPS_PER_FETCH = 4,
  parameter logic [WIDTH-1:0] SEED_DEFAULT    = SEED_DEFAULT_W12,
  parameter logic [WIDTH-1:0] CH_SALT         = CH_SALT_W12
`ifdef LFSR_MULTI_RANGE_EN
  ,
  parameter logic [WIDTH-1:0] LIMIT           = 12'd640,
  parameter int               MAX_RETRY       = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH*WIDTH-1:0] seed_in,
  input  logic                    fetch,
  output logic [NUM_CH*WIDTH-1:0] coord,
  output logic                    ack,
  output logic                    busy,
  output logic                    seeded,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = 16;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH*WIDTH-1:0] coord_q, coord_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    seeded_q, seeded_d;

  logic                    step_en;
  logic                    done;
  logic [NUM_CH*WIDTH-1:0] load_all;
  logic [NUM_CH*WIDTH-1:0] next_all;
  logic [NUM_CH*WIDTH-1:0] out_all;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Salting keeps channels decorrelated when they share a seed value.
    localparam logic [WIDTH-1:0] SALT = WIDTH'(c * int'(CH_SALT));

    lfsr_core #(
      .WIDTH        (WIDTH),
      .TAPS         (TAPS),
      .SEED_DEFAULT (SEED_DEFAULT)
    ) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .step     (step_en),
      .seed     (seed_in[c*WIDTH +: WIDTH] ^ SALT),
      .load_val (load_all[c*WIDTH +: WIDTH]),
      .next_val (next_all[c*WIDTH +: WIDTH])
    );
  end

`ifdef LFSR_MULTI_RANGE_EN
  logic any_hi;

  // After the mandatory steps, keep stepping while any channel is out of
  // range; once retries run out, out-of-range channels saturate to LIMIT-1.
  always_comb begin
    any_hi  = 1'b0;
    out_all = next_all;
    for (int i = 0; i < NUM_CH; i++) begin
      if (next_all[i*WIDTH +: WIDTH] >= LIMIT) begin
        any_hi                    = 1'b1;
        out_all[i*WIDTH +: WIDTH] = LIMIT - WIDTH'(1);
      end
    end
    done = (cnt_q >= CNT_W'(STEPS_PER_FETCH - 1)) &&
           (!any_hi || (cnt_q == CNT_W'(STEPS_PER_FETCH + MAX_RETRY - 1)));
  end
`else
  assign out_all = next_all;
  // cnt_q counts completed steps; this edge performs step cnt_q+1.
  assign done    = (cnt_q == CNT_W'(STEPS_PER_FETCH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coord_d  = coord_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    seeded_d = seeded_q;
    step_en  = 1'b0;
    if (start) begin
      // Load wins over fetch and aborts any stepping without an ack.
      state_d  = READY;
      cnt_d    = '0;
      coord_d  = load_all;
      busy_d   = 1'b0;
      seeded_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        READY: begin
          if (fetch) begin
            state_d = STEP;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        STEP: begin
          step_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (done) begin
            coord_d = out_all;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      coord_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      seeded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      coord_q  <= coord_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      seeded_q <= seeded_d;
    end
  end

  assign coord     = coord_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign seeded    = seeded_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi: self-checking bench for lfsr_multi.
// u_def: default parameters (2 channels, 4 steps per fetch).
// u_s1 : one channel, one step per fetch (single-step and period checks).
// u_rng: range-limited build, present only with LFSR_MULTI_RANGE_EN.
module tb_lfsr_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        d_start, d_fetch, d_ack, d_busy, d_seeded;
  logic [23:0] d_seed, d_coord;
  logic [1:0]  d_dbg;

  logic        s_start, s_fetch, s_ack, s_busy, s_seeded;
  logic [11:0] s_seed, s_coord;
  logic [1:0]  s_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] m_def [2];
  logic [11:0] m_s1;
  logic [23:0] exp_q [$];

  lfsr_multi u_def (
    .clk(clk), .reset(reset), .start(d_start), .seed_in(d_seed), .fetch(d_fetch),
    .coord(d_coord), .ack(d_ack), .busy(d_busy), .seeded(d_seeded), .dbg_state(d_dbg)
  );

  lfsr_multi #(.NUM_CH(1), .STEPS_PER_FETCH(1)) u_s1 (
    .clk(clk), .reset(reset), .start(s_start), .seed_in(s_seed), .fetch(s_fetch),
    .coord(s_coord), .ack(s_ack), .busy(s_busy), .seeded(s_seeded), .dbg_state(s_dbg)
  );

`ifdef LFSR_MULTI_RANGE_EN
  logic        r_start, r_fetch, r_ack, r_busy, r_seeded;
  logic [23:0] r_seed, r_coord;
  logic [1:0]  r_dbg;
  logic [11:0] m_r [2];

  lfsr_multi #(.LIMIT(12'd640), .MAX_RETRY(8)) u_rng (
    .clk(clk), .reset(reset), .start(r_start), .seed_in(r_seed), .fetch(r_fetch),
    .coord(r_coord), .ack(r_ack), .busy(r_busy), .seeded(r_seeded), .dbg_state(r_dbg)
  );
`endif

  // ---------------- reference model ----------------
  // Advance a 12-bit Fibonacci LFSR (mask 0xE08, shift towards MSB) n times.
  function automatic logic [11:0] lfsr_adv(input logic [11:0] s, input int n);
    int v;
    int fb;
    v = int'(s);
    for (int k = 0; k < n; k++) begin
      fb = 0;
      for (int i = 0; i < 12; i++) begin
        if ((((v >> i) & 1) == 1) && (((32'hE08 >> i) & 1) == 1)) fb = fb ^ 1;
      end
      v = ((v << 1) | fb) & 32'hFFF;
    end
    return v[11:0];
  endfunction

  function automatic logic [11:0] load_model(input logic [11:0] seed, input int c);
    int v;
    v = (int'(seed) ^ (c * 32'h5A5)) & 32'hFFF;
    if (v == 0) v = 32'hACE;
    return v[11:0];
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic load_def(input logic [23:0] seed);
    d_seed  = seed;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    m_def[0] = load_model(seed[11:0], 0);
    m_def[1] = load_model(seed[23:12], 1);
  endtask

  task automatic fetch_def(output int lat);
    d_fetch = 1'b1;
    @(negedge clk);
    d_fetch = 1'b0;
    lat = 1;
    while (d_ack !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic load_s1(input logic [11:0] seed);
    s_seed  = seed;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic fetch_s1(output int lat);
    s_fetch = 1'b1;
    @(negedge clk);
    s_fetch = 1'b0;
    lat = 1;
    while (s_ack !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    d_start = 1'b0; d_fetch = 1'b0; d_seed = '0;
    s_start = 1'b0; s_fetch = 1'b0; s_seed = '0;
`ifdef LFSR_MULTI_RANGE_EN
    r_start = 1'b0; r_fetch = 1'b0; r_seed = '0;
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if (d_coord !== 24'h0 || d_ack !== 1'b0 || d_busy !== 1'b0 || d_seeded !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_def: coord=%h ack=%b busy=%b seeded=%b, required 0/0/0/0",
               d_coord, d_ack, d_busy, d_seeded);
    end
    n_tests++;
    if (d_dbg !== 2'(lfsr_pkg::IDLE) || s_dbg !== 2'(lfsr_pkg::IDLE)) begin
      n_fail++;
      $display("FAIL reset_state: def=%0d s1=%0d, required IDLE", d_dbg, s_dbg);
    end
    n_tests++;
    if (s_coord !== 12'h0 || s_ack !== 1'b0 || s_busy !== 1'b0 || s_seeded !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_s1: coord=%h ack=%b busy=%b seeded=%b, required 0", s_coord, s_ack,
               s_busy, s_seeded);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_fetch;
    d_fetch = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (d_ack !== 1'b0 || d_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_fetch: cycle %0d ack=%b busy=%b, required 0/0", i, d_ack, d_busy);
      end
    end
    d_fetch = 1'b0;
  endtask

  task automatic test_seed_load;
    load_def({12'h000, 12'h001});
    n_tests++;
    if (d_coord !== {12'h5A5, 12'h001} || d_seeded !== 1'b1 || d_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_load: coord=%h seeded=%b ack=%b, required 5a5001/1/0", d_coord,
               d_seeded, d_ack);
    end
    n_tests++;
    if (d_dbg !== 2'(lfsr_pkg::READY)) begin
      n_fail++;
      $display("FAIL seed_load_state: state=%0d, required READY", d_dbg);
    end
  endtask

  task automatic test_fetch_random;
    logic [23:0] seed, exp;
    int          lat, nf, gap;
    for (int it = 0; it < 12; it++) begin
      seed = 24'($urandom);
      if (it == 3) seed = 24'h000000;
      if (it == 4) seed = {12'h5A5, 12'h000};
      load_def(seed);
      n_tests++;
      if (d_coord !== {m_def[1], m_def[0]}) begin
        n_fail++;
        $display("FAIL rand_load: seed=%h coord=%h, required %h", seed, d_coord,
                 {m_def[1], m_def[0]});
      end
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        m_def[0] = lfsr_adv(m_def[0], 4);
        m_def[1] = lfsr_adv(m_def[1], 4);
        exp_q.push_back({m_def[1], m_def[0]});
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        fetch_def(lat);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat != 5) begin
          n_fail++;
          $display("FAIL rand_latency: latency=%0d, required 5", lat);
        end
        n_tests++;
        if (d_coord !== exp) begin
          n_fail++;
          $display("FAIL rand_coord: coord=%h, required %h", d_coord, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp;
    d_fetch = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 30) d_fetch = 1'b0;
      n_tests++;
      if (d_ack !== ((i % 5) == 0) || d_busy !== ((i % 5) != 0)) begin
        n_fail++;
        $display("FAIL b2b_timing: cycle %0d ack=%b busy=%b, required %b/%b", i, d_ack, d_busy,
                 (i % 5) == 0, (i % 5) != 0);
      end
      if ((i % 5) == 0) begin
        m_def[0] = lfsr_adv(m_def[0], 4);
        m_def[1] = lfsr_adv(m_def[1], 4);
        exp = {m_def[1], m_def[0]};
        n_tests++;
        if (d_coord !== exp) begin
          n_fail++;
          $display("FAIL b2b_coord: cycle %0d coord=%h, required %h", i, d_coord, exp);
        end
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [23:0] exp;
    d_fetch = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      d_fetch = (i == 2 || i == 3);
      n_tests++;
      if (d_ack !== (i == 5)) begin
        n_fail++;
        $display("FAIL busy_ignore: cycle %0d ack=%b, required %b", i, d_ack, i == 5);
      end
      if (i == 5) begin
        m_def[0] = lfsr_adv(m_def[0], 4);
        m_def[1] = lfsr_adv(m_def[1], 4);
        exp = {m_def[1], m_def[0]};
        n_tests++;
        if (d_coord !== exp) begin
          n_fail++;
          $display("FAIL busy_ignore_coord: coord=%h, required %h", d_coord, exp);
        end
      end
    end
  endtask

  task automatic test_abort;
    logic [23:0] seed_b;
    int          lat;
    load_def(24'($urandom));
    seed_b  = 24'($urandom);
    d_fetch = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      d_fetch = 1'b0;
      if (i == 2) begin
        d_seed  = seed_b;
        d_start = 1'b1;
      end else begin
        d_start = 1'b0;
      end
      n_tests++;
      if (d_ack !== 1'b0 || d_busy !== (i <= 2)) begin
        n_fail++;
        $display("FAIL abort_no_ack: cycle %0d ack=%b busy=%b, required 0/%b", i, d_ack,
                 d_busy, i <= 2);
      end
    end
    m_def[0] = load_model(seed_b[11:0], 0);
    m_def[1] = load_model(seed_b[23:12], 1);
    n_tests++;
    if (d_coord !== {m_def[1], m_def[0]}) begin
      n_fail++;
      $display("FAIL abort_reload: coord=%h, required %h", d_coord, {m_def[1], m_def[0]});
    end
    fetch_def(lat);
    m_def[0] = lfsr_adv(m_def[0], 4);
    m_def[1] = lfsr_adv(m_def[1], 4);
    n_tests++;
    if (lat != 5 || d_coord !== {m_def[1], m_def[0]}) begin
      n_fail++;
      $display("FAIL abort_next_fetch: latency=%0d coord=%h, required 5/%h", lat, d_coord,
               {m_def[1], m_def[0]});
    end
  endtask

  task automatic test_reset_mid_step;
    d_fetch = 1'b1;
    @(negedge clk);
    d_fetch = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (d_coord !== 24'h0 || d_ack !== 1'b0 || d_busy !== 1'b0 || d_seeded !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_step: coord=%h ack=%b busy=%b seeded=%b, required 0/0/0/0",
               d_coord, d_ack, d_busy, d_seeded);
    end
    d_fetch = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (d_ack !== 1'b0 || d_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: cycle %0d ack=%b busy=%b, required 0/0", i, d_ack,
                 d_busy);
      end
    end
    d_fetch = 1'b0;
  endtask

  task automatic test_single_step;
    int lat;
    load_s1(12'h001);
    n_tests++;
    if (s_coord !== 12'h001) begin
      n_fail++;
      $display("FAIL s1_load: coord=%h, required 001", s_coord);
    end
    fetch_s1(lat);
    n_tests++;
    if (lat != 2 || s_coord !== 12'h002) begin
      n_fail++;
      $display("FAIL s1_step_001: latency=%0d coord=%h, required 2/002", lat, s_coord);
    end
    load_s1(12'h800);
    fetch_s1(lat);
    n_tests++;
    if (lat != 2 || s_coord !== 12'h001) begin
      n_fail++;
      $display("FAIL s1_step_800: latency=%0d coord=%h, required 2/001", lat, s_coord);
    end
  endtask

  task automatic test_period;
    int lat, first_rep, zero_seen, bad_val, bad_lat;
    load_s1(12'h000);
    n_tests++;
    if (s_coord !== 12'hACE) begin
      n_fail++;
      $display("FAIL zero_seed: coord=%h, required ace", s_coord);
    end
    m_s1 = 12'hACE;
    first_rep = 0; zero_seen = 0; bad_val = 0; bad_lat = 0;
    for (int n = 1; n <= 4095; n++) begin
      fetch_s1(lat);
      m_s1 = lfsr_adv(m_s1, 1);
      if (lat != 2) bad_lat++;
      if (s_coord !== m_s1) bad_val++;
      if (s_coord == 12'h000) zero_seen++;
      if (s_coord == 12'hACE && first_rep == 0) first_rep = n;
    end
    n_tests++;
    if (bad_val != 0 || bad_lat != 0) begin
      n_fail++;
      $display("FAIL period_values: %0d value and %0d latency errors, required 0", bad_val,
               bad_lat);
    end
    n_tests++;
    if (zero_seen != 0) begin
      n_fail++;
      $display("FAIL period_zero: all-zero seen %0d times, required 0", zero_seen);
    end
    n_tests++;
    if (first_rep != 4095) begin
      n_fail++;
      $display("FAIL period_length: first repeat at fetch %0d, required 4095", first_rep);
    end
  endtask

`ifdef LFSR_MULTI_RANGE_EN
  task automatic test_range;
    logic [23:0] seed, exp;
    int          lat, r, exp_lat, bad_bound, bad_lat, bad_exact, bad_coord;
    bad_bound = 0; bad_lat = 0; bad_exact = 0; bad_coord = 0;
    for (int n = 0; n < 1000; n++) begin
      if ((n % 100) == 0) begin
        seed    = 24'($urandom);
        r_seed  = seed;
        r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        m_r[0] = load_model(seed[11:0], 0);
        m_r[1] = load_model(seed[23:12], 1);
      end
      m_r[0] = lfsr_adv(m_r[0], 4);
      m_r[1] = lfsr_adv(m_r[1], 4);
      r = 0;
      while ((m_r[0] >= 12'd640 || m_r[1] >= 12'd640) && r < 8) begin
        m_r[0] = lfsr_adv(m_r[0], 1);
        m_r[1] = lfsr_adv(m_r[1], 1);
        r++;
      end
      exp = {(m_r[1] >= 12'd640) ? 12'd639 : m_r[1], (m_r[0] >= 12'd640) ? 12'd639 : m_r[0]};
      exp_lat = 5 + r;
      r_fetch = 1'b1;
      @(negedge clk);
      r_fetch = 1'b0;
      lat = 1;
      while (r_ack !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      if (r_coord[11:0] >= 12'd640 || r_coord[23:12] >= 12'd640) bad_bound++;
      if (lat < 5 || lat > 13) bad_lat++;
      if (lat != exp_lat) bad_exact++;
      if (r_coord !== exp) bad_coord++;
    end
    n_tests++;
    if (bad_bound != 0) begin
      n_fail++;
      $display("FAIL range_bound: %0d outputs >= 640, required 0", bad_bound);
    end
    n_tests++;
    if (bad_lat != 0 || bad_exact != 0) begin
      n_fail++;
      $display("FAIL range_latency: %0d out of 5..13, %0d not matching model, required 0/0",
               bad_lat, bad_exact);
    end
    n_tests++;
    if (bad_coord != 0) begin
      n_fail++;
      $display("FAIL range_coord: %0d coordinate sets differ from model, required 0", bad_coord);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_idle_fetch();
    test_seed_load();
    test_fetch_random();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_reset_mid_step();
    test_single_step();
    test_period();
`ifdef LFSR_MULTI_RANGE_EN
    test_range();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_multi.md
Name: lfsr_multi

Overview:
- Parametrised, multi-channel successor to the team's 12-bit random coordinate generator.
- Holds NUM_CH independent Fibonacci LFSRs of WIDTH bits, for example X and Y spawn coordinates.
- Seeds all channels on start. On each fetch it advances every channel by STEPS_PER_FETCH shifts, then presents fresh registered coordinates with a one-cycle ack.
- Sits between the game-logic FSM (fetch/ack requester) and the seed generator (seed source).

Parameters:
- WIDTH, 12: bits per channel.
- NUM_CH, 2: number of independent channels.
- TAPS, 12'hE08: feedback mask; bit i set means state[i] feeds the XOR. Default is maximal-length x^12+x^11+x^10+x^4+1.
- STEPS_PER_FETCH, 4: shifts per fetch; must be at least 1.
- SEED_DEFAULT, 12'hACE: substituted for an all-zero channel seed.
- CH_SALT, 12'h5A5: channel c is loaded with seed_c XOR (c*CH_SALT), truncated to WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; while high, reload all channels from seed_in.
- seed_in  in  NUM_CH*WIDTH  channel c occupies [c*WIDTH +: WIDTH].
- fetch  in  1  request for a new coordinate set.
- coord  out  NUM_CH*WIDTH  registered outputs, same packing as seed_in.
- ack  out  1  one-cycle pulse; coord is new this cycle.
- busy  out  1  high while stepping.
- seeded  out  1  high once any seed load has occurred since reset.

Behaviour:
- Reset values: all LFSR states 0, coord 0, ack 0, busy 0, seeded 0, step counter 0, FSM in IDLE.
- FSM states IDLE, READY, STEP.
- IDLE:
  - fetch is ignored; no ack is issued.
  - start goes to READY.
- Load (any state while start=1):
  - Each state_c <= seed_c ^ (c*CH_SALT).
  - If that result is 0, load SEED_DEFAULT instead, so no lockup is possible.
  - seeded <= 1; coord <= loaded values; ack 0.
  - start has priority over fetch and over an in-progress STEP. An aborted STEP yields no ack.
  - FSM stays in or enters READY when start falls.
- Step function, per channel: next = {s[WIDTH-2:0], ^(s & TAPS)}. Feedback is computed from the pre-shift state.
- READY with fetch=1 and start=0: enter STEP, busy=1, counter <= 0.
- STEP:
  - Every edge, all channels step and the counter increments.
  - On the edge performing step number STEPS_PER_FETCH: coord <= the stepped states, ack <= 1, busy <= 0, return to READY.
- Latency: fetch sampled at edge t gives ack high in the cycle following edge t+STEPS_PER_FETCH.
- Intermediate states are never visible on coord.
- fetch while busy is ignored, not queued.
- fetch held high continuously gives back-to-back fetches: ack every STEPS_PER_FETCH+1 cycles.
- ack is never high in two consecutive cycles.
- reset asserted mid-STEP returns to the reset values on the next edge.
- The period of each channel with default TAPS is 4095; the all-zero state is unreachable.

Optional Feature:
- Macro LFSR_MULTI_RANGE_EN adds parameters LIMIT (default 12'd640) and MAX_RETRY (default 8).
- With the macro, after STEPS_PER_FETCH steps, if any channel is >= LIMIT, all channels keep stepping one more step per cycle. This continues until all channels are < LIMIT or MAX_RETRY extra steps are done.
- Any channel still >= LIMIT is output as LIMIT-1.
- ack is issued at completion. Worst-case latency is STEPS_PER_FETCH+MAX_RETRY+1.
- Without the macro, the rejection logic is absent and outputs span the full WIDTH.

Decomposition:
- Package lfsr_pkg holds:
  - the FSM state enum (IDLE, READY, STEP);
  - maximal-length TAPS constants for widths 8–16;
  - the default SEED_DEFAULT and CH_SALT values.
- Sub-module lfsr_core is one WIDTH-bit register with load/step/seed-zero substitution. It is instantiated NUM_CH times by a generate loop. lfsr_multi owns the FSM, counter, ack and range logic.

Test Plan:
- Reset, then start with seed {12'h000, 12'h001} (ch1, ch0) → coord ch0 = 12'h001; ch1 = 12'h000 ^ 12'h5A5 = 12'h5A5; seeded = 1; ack = 0.
- STEPS_PER_FETCH=1, ch0 state 12'h001, fetch → ack one cycle later, ch0 = 12'h002. From 12'h800, fetch → 12'h001.
- Zero seed on ch0 (NUM_CH=1) → state 12'hACE. 4095 single-step fetches return 12'hACE with no all-zero value seen; the first repeat occurs exactly at fetch 4095.
- fetch high continuously, default parameters → ack pulses exactly every 5 cycles; busy high for 4 cycles between; fetch pulses during busy produce no extra ack.
- start asserted two cycles into STEP → no ack; coord equals the reloaded seeds; the next fetch behaves normally.
- With LFSR_MULTI_RANGE_EN, LIMIT=640, over 1000 fetches → every channel < 640; ack latency is between 5 and 13 cycles.
